// File: rtl/simple_cpu.sv
// Single-cycle 8-bit accumulator-less CPU: each edge decodes one 16-bit word
// (opcode, two 4-bit immediates) and registers the ALU result.

module simple_cpu_fetch #(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = 4
) (
    input  logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr
);
    // Loaded hierarchically from outside; nothing in the CPU writes it.
    logic [15:0] memory [0:MEM_DEPTH-1];

    assign instr = memory[pc];
endmodule

module simple_cpu #(
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] result
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_MUL  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        result_q, result_d;
    logic [15:0]       instr;
    logic [3:0]        opcode;
    logic [7:0]        op_a, op_b;

    simple_cpu_fetch #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) fetch_inst (
        .pc    (pc_q),
        .instr (instr)
    );

    assign opcode = instr[15:12];
    assign op_a   = {4'b0000, instr[11:8]};
    assign op_b   = {4'b0000, instr[7:4]};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        result_d = result_q;
        if (state_q == ST_RUN) begin
            // PC wraps naturally since MEM_DEPTH == 2**ADDR_W.
            pc_d = pc_q + 1'b1;
            case (opcode)
                OP_ADD:  result_d = op_a + op_b;
                OP_SUB:  result_d = op_a - op_b;
                OP_AND:  result_d = op_a & op_b;
                OP_OR:   result_d = op_a | op_b;
                OP_XOR:  result_d = op_a ^ op_b;
                OP_MUL:  result_d = op_a * op_b;
                OP_SHL:  result_d = op_a << op_b;
                OP_SHR:  result_d = op_a >> op_b;
                OP_HALT: begin
                    state_d = ST_HALT;
                    pc_d    = pc_q;
                end
                // Undefined and unknown opcodes fall through as NOP.
                default: result_d = result_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            result_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
endmodule

// File: tb/tb_simple_cpu.sv
// Self-checking bench for simple_cpu: programs are loaded under reset and the
// expected result of every executed edge is queued, then popped as it appears.

module tb_simple_cpu;
    logic       clk;
    logic       rst;
    logic [7:0] result;

    logic [7:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    simple_cpu cpu (
        .clk    (clk),
        .rst    (rst),
        .result (result)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [15:0] ins, input logic [7:0] prev);
        logic [7:0] a, b;
        a = {4'b0000, ins[11:8]};
        b = {4'b0000, ins[7:4]};
        case (ins[15:12])
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a | b;
            4'h4:    return a ^ b;
            4'h5:    return a * b;
            4'h6:    return a << b;
            4'h7:    return a >> b;
            default: return prev;
        endcase
    endfunction

    // Driver tasks
    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("reset_result", result, 8'h00);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) cpu.fetch_inst.memory[i] = 16'h8000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: pops one expectation per executed edge.
    task automatic run_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: scoreboard empty at cycle %0d, got %0d", tag, i, result);
            end else begin
                check_val(tag, result, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        logic [15:0] prog [0:15];
        logic [7:0]  res;
        logic [3:0]  pc;
        logic [3:0]  nib;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        #10;
        check_val("reset_init", result, 8'h00);

        // ADD then SUB, trailing words NOP so the result must hold.
        enter_reset();
        fill_nop();
        cpu.fetch_inst.memory[0] = 16'h0120;
        cpu.fetch_inst.memory[1] = 16'h1210;
        exp_q.push_back(8'd3);
        for (int i = 0; i < 11; i++) exp_q.push_back(8'd1);
        release_reset();
        run_check("add_sub", 12);

        // SUB underflow, max MUL, ADD of maxima.
        enter_reset();
        fill_nop();
        cpu.fetch_inst.memory[0] = 16'h1120;
        cpu.fetch_inst.memory[1] = 16'h5FF0;
        cpu.fetch_inst.memory[2] = 16'h0FF0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'd225);
        exp_q.push_back(8'd30);
        exp_q.push_back(8'd30);
        release_reset();
        run_check("sub_mul_add", 4);

        // Logic ops and shifts.
        enter_reset();
        fill_nop();
        cpu.fetch_inst.memory[0] = 16'h2C60;
        cpu.fetch_inst.memory[1] = 16'h3C60;
        cpu.fetch_inst.memory[2] = 16'h4C60;
        cpu.fetch_inst.memory[3] = 16'h6F40;
        cpu.fetch_inst.memory[4] = 16'h7F20;
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd14);
        exp_q.push_back(8'd10);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'd3);
        release_reset();
        run_check("logic_shift", 5);

        // HALT freezes result, reset releases it.
        enter_reset();
        fill_nop();
        cpu.fetch_inst.memory[0] = 16'h0110;
        cpu.fetch_inst.memory[1] = 16'hF000;
        cpu.fetch_inst.memory[2] = 16'h0770;
        for (int i = 0; i < 25; i++) exp_q.push_back(8'd2);
        release_reset();
        run_check("halt_hold", 25);
        enter_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'd2);
        release_reset();
        run_check("halt_rerun", 4);

        // PC wrap: each word yields its own address.
        enter_reset();
        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            cpu.fetch_inst.memory[i] = {4'h0, nib, 8'h00};
        end
        for (int i = 0; i < 18; i++) exp_q.push_back(8'(i % 16));
        release_reset();
        run_check("pc_wrap", 18);

        // Asynchronous reset between edges, then restart from address 0.
        enter_reset();
        for (int i = 0; i < 16; i++) begin
            nib = 4'(15 - i);
            cpu.fetch_inst.memory[i] = {4'h0, nib, 8'h00};
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(15 - i));
        release_reset();
        run_check("pre_abort", 6);
        #3;
        rst = 1'b1;
        #1;
        check_val("async_reset", result, 8'h00);
        for (int i = 0; i < 3; i++) exp_q.push_back(8'(15 - i));
        release_reset();
        run_check("restart", 3);

        // Random ALU/NOP programs against the reference model, with wrap.
        for (int t = 0; t < 3; t++) begin
            enter_reset();
            for (int i = 0; i < 16; i++) begin
                prog[i] = 16'($urandom_range(0, 16'hEFFF));
                cpu.fetch_inst.memory[i] = prog[i];
            end
            res = 8'h00;
            pc  = 4'h0;
            for (int c = 0; c < 20; c++) begin
                res = model(prog[pc], res);
                exp_q.push_back(res);
                pc = pc + 4'h1;
            end
            release_reset();
            run_check("random", 20);
        end

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover: got %0d queued expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/simple_cpu.md
SIMPLE_CPU -- requirements
Module: simple_cpu

Interface
REQ-001 Parameter MEM_DEPTH, default 16, SHALL set the number of 16-bit instruction words.
REQ-002 Parameter ADDR_W, default 4, SHALL set the program counter (PC) width; MEM_DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 result  output  8  SHALL be the registered ALU result of the last executed instruction.
REQ-006 Instruction memory SHALL live in a fetch submodule instance named fetch_inst, as an array named memory[0:MEM_DEPTH-1] of 16-bit words, writable hierarchically by a bench (cpu.fetch_inst.memory[n]).

Function
REQ-007 Instruction format SHALL be [15:12] opcode, [11:8] operand1, [7:4] operand2, [3:0] unused/ignored.
REQ-008 Operands SHALL be 4-bit immediates, zero-extended to 8 bits before use.
REQ-009 Opcode 0x0 ADD: result = op1 + op2 (mod 256).
REQ-010 Opcode 0x1 SUB: result = op1 - op2 (mod 256); 1-2 SHALL give 8'hFF.
REQ-011 Opcodes 0x2 AND, 0x3 OR, 0x4 XOR: bitwise on the zero-extended operands.
REQ-012 Opcode 0x5 MUL: result = op1 * op2 (max 225, no truncation).
REQ-013 Opcode 0x6 SHL: result = (op1 << op2) truncated to 8 bits; 0x7 SHR: result = op1 >> op2.
REQ-014 Opcode 0xF HALT: result SHALL hold, PC SHALL stop advancing, and the CPU SHALL remain halted until reset.
REQ-015 Opcode 0x8 and all other undefined opcodes, including non-0/1 (X/Z) opcodes in simulation, SHALL act as NOP: result holds, PC advances.
REQ-016 Execution SHALL be single-cycle: on each rising edge while not in reset and not halted, the instruction at memory[PC] is decoded, result is loaded per REQ-009..015, and PC increments by 1.
REQ-017 Latency: the first rising edge after rst deasserts SHALL execute memory[0]; instruction N's result SHALL be visible on result after the (N+1)th edge.
REQ-018 PC SHALL wrap from MEM_DEPTH-1 to 0.
REQ-019 Instruction memory read SHALL be combinational from PC within fetch_inst; the CPU SHALL never write memory.

Reset
REQ-020 While rst=1, result SHALL be 8'h00, PC SHALL be 0, and the halted flag SHALL be clear, all immediately on assertion without waiting for clk.
REQ-021 Reset SHALL NOT clear or modify instruction memory; words written while rst=1 SHALL persist.
REQ-022 Reset asserted mid-program SHALL abort the current cycle; after release, execution SHALL restart at address 0.
REQ-023 Reset SHALL release a HALT state.

Verification
REQ-024 mem[0]=0x0120 (ADD 1,2), mem[1]=0x1210 (SUB 2,1), rest unwritten; rst for 10 ns; then: after 1st edge result=3, after 2nd edge result=1, holds 1 through 10 cycles.
REQ-025 mem[0]=0x1120 (SUB 1,2) -> result=8'hFF; mem[1]=0x5FF0 (MUL 15,15) -> result=225; mem[2]=0x0FF0 (ADD) -> result=30.
REQ-026 mem[0]=0x2C60 AND -> 4; mem[1]=0x3C60 OR -> 14; mem[2]=0x4C60 XOR -> 10; mem[3]=0x6F40 SHL 15,4 -> 8'hF0; mem[4]=0x7F20 SHR -> 3.
REQ-027 mem[0]=0x0110 -> 2; mem[1]=0xF000 HALT; mem[2]=0x0770 -> result SHALL stay 2 indefinitely; pulse rst -> result=0, rerun gives 2 again.
REQ-028 All 16 words = ADD with op1=n, op2=0 -> result cycles 0..15 and wraps back to 0 on the 17th edge.
REQ-029 Assert rst between clock edges mid-run -> result goes to 0 before the next edge; after release, memory[0] executes first.
